// File: rtl/conv_top.sv
// conv_top: binary-weight multiply-accumulate engine for CH_NUM channels.
// The conv path applies one shared K*K window to per-channel weights.
// The FC path applies a per-channel K*K slice to per-channel weights.
// Optional build macro CONV_TOP_SAT_EN: saturate channel sums instead of wrapping.
module conv_top #(
  parameter int CONV_DATA_WIDTH = 1,
  parameter int FC_DATA_WIDTH   = 6,
  parameter int K               = 4,
  parameter int LOGK            = 4,
  parameter int CH_NUM          = 6
) (
  input  logic                                         clk,
  input  logic                                         rstn,
  input  logic                                         conv_valid,
  output logic                                         conv_ready,
  input  logic                                         fc_valid,
  output logic                                         fc_ready,
  input  logic                                         weight_ready,
  output logic                                         weight_req,
  input  logic [CH_NUM*K*K-1:0]                        weight,
  input  logic [K*K*CONV_DATA_WIDTH-1:0]               conv_data_in,
  input  logic [CH_NUM*K*K*FC_DATA_WIDTH-1:0]          fc_data_in,
  output logic [CH_NUM*(CONV_DATA_WIDTH+LOGK+1)-1:0]   conv_data_out,
  output logic [CH_NUM*(FC_DATA_WIDTH+LOGK)-1:0]       fc_data_out,
  output logic                                         out_conv_valid,
  output logic                                         out_fc_valid
);

  localparam int KK  = K * K;
  localparam int CDW = CONV_DATA_WIDTH;
  localparam int FDW = FC_DATA_WIDTH;
  localparam int CW  = CDW + LOGK + 1;  // conv output width per channel
  localparam int FW  = FDW + LOGK;      // fc output width per channel
  localparam int CSW = CW + 1;          // full-precision conv accumulator
  localparam int FSW = FW + 2;          // full-precision fc accumulator

  logic [CH_NUM*KK-1:0] r_wq;
  logic                 r_loaded;
  logic                 r_fresh;
  logic [CH_NUM*CW-1:0] r_conv_out_p1;
  logic [CH_NUM*FW-1:0] r_fc_out_p1;
  logic                 r_conv_vld_p1;
  logic                 r_fc_vld_p1;

  logic                 w_conv_acc;
  logic                 w_fc_acc;
  logic [CH_NUM*CW-1:0] w_conv_sum_p0;
  logic [CH_NUM*FW-1:0] w_fc_sum_p0;

  // Signed accumulate of K*K conv terms, each added or subtracted by its weight bit.
  function automatic logic signed [CSW-1:0] conv_sum(input logic [KK-1:0] w,
                                                     input logic [KK*CDW-1:0] x);
    logic signed [CSW-1:0] acc;
    logic signed [CSW-1:0] t;
    acc = '0;
    for (int k = 0; k < KK; k++) begin
      t   = CSW'($signed(x[k*CDW +: CDW]));
      acc = w[k] ? (acc + t) : (acc - t);
    end
    return acc;
  endfunction

  // Signed accumulate of one channel's K*K fc terms.
  function automatic logic signed [FSW-1:0] fc_sum(input logic [KK-1:0] w,
                                                   input logic [KK*FDW-1:0] x);
    logic signed [FSW-1:0] acc;
    logic signed [FSW-1:0] t;
    acc = '0;
    for (int k = 0; k < KK; k++) begin
      t   = FSW'($signed(x[k*FDW +: FDW]));
      acc = w[k] ? (acc + t) : (acc - t);
    end
    return acc;
  endfunction

  // Reduce a full-precision conv sum to the output width (saturate or wrap).
  function automatic logic signed [CW-1:0] fit_conv(input logic signed [CSW-1:0] s);
`ifdef CONV_TOP_SAT_EN
    logic signed [CSW-1:0] hi;
    logic signed [CSW-1:0] lo;
    hi = '0;
    hi[CW-2:0] = '1;
    lo = '1;
    lo[CW-2:0] = '0;
    if (s > hi)      return hi[CW-1:0];
    else if (s < lo) return lo[CW-1:0];
    else             return s[CW-1:0];
`else
    return s[CW-1:0];
`endif
  endfunction

  // Reduce a full-precision fc sum to the output width (saturate or wrap).
  function automatic logic signed [FW-1:0] fit_fc(input logic signed [FSW-1:0] s);
`ifdef CONV_TOP_SAT_EN
    logic signed [FSW-1:0] hi;
    logic signed [FSW-1:0] lo;
    hi = '0;
    hi[FW-2:0] = '1;
    lo = '1;
    lo[FW-2:0] = '0;
    if (s > hi)      return hi[FW-1:0];
    else if (s < lo) return lo[FW-1:0];
    else             return s[FW-1:0];
`else
    return s[FW-1:0];
`endif
  endfunction

  assign weight_req = !r_fresh;
  assign conv_ready = r_loaded;
  assign fc_ready   = r_fresh;
  assign w_conv_acc = conv_valid && r_loaded;
  assign w_fc_acc   = fc_valid && r_fresh;

  // Stage p0: per-channel sums from the currently held weight set.
  for (genvar ch = 0; ch < CH_NUM; ch++) begin : g_ch
    assign w_conv_sum_p0[ch*CW +: CW] = fit_conv(conv_sum(r_wq[ch*KK +: KK], conv_data_in));
    assign w_fc_sum_p0[ch*FW +: FW]   = fit_fc(fc_sum(r_wq[ch*KK +: KK],
                                                      fc_data_in[ch*KK*FDW +: KK*FDW]));
  end

  // Weight register and its loaded/fresh flags; a load wins over an fc consume.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_wq     <= '0;
      r_loaded <= 1'b0;
      r_fresh  <= 1'b0;
    end else begin
      if (weight_ready) begin
        r_wq     <= weight;
        r_loaded <= 1'b1;
        r_fresh  <= 1'b1;
      end else if (w_fc_acc) begin
        r_fresh  <= 1'b0;
      end
    end
  end

  // Stage p1: result registers hold until the next accept; valids pulse one cycle.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_conv_out_p1 <= '0;
      r_fc_out_p1   <= '0;
      r_conv_vld_p1 <= 1'b0;
      r_fc_vld_p1   <= 1'b0;
    end else begin
      r_conv_vld_p1 <= w_conv_acc;
      r_fc_vld_p1   <= w_fc_acc;
      if (w_conv_acc) r_conv_out_p1 <= w_conv_sum_p0;
      if (w_fc_acc)   r_fc_out_p1   <= w_fc_sum_p0;
    end
  end

  assign conv_data_out  = r_conv_out_p1;
  assign fc_data_out    = r_fc_out_p1;
  assign out_conv_valid = r_conv_vld_p1;
  assign out_fc_valid   = r_fc_vld_p1;

endmodule

// File: tb/tb_conv_top.sv
// tb_conv_top: directed-vector bench for conv_top with default parameters.
module tb_conv_top;

  logic         clk;
  logic         rstn;
  logic         conv_valid;
  logic         conv_ready;
  logic         fc_valid;
  logic         fc_ready;
  logic         weight_ready;
  logic         weight_req;
  logic [95:0]  weight;
  logic [15:0]  conv_data_in;
  logic [575:0] fc_data_in;
  logic [35:0]  conv_data_out;
  logic [59:0]  fc_data_out;
  logic         out_conv_valid;
  logic         out_fc_valid;

  int n_tests;
  int n_fail;

  conv_top dut (
    .clk           (clk),
    .rstn          (rstn),
    .conv_valid    (conv_valid),
    .conv_ready    (conv_ready),
    .fc_valid      (fc_valid),
    .fc_ready      (fc_ready),
    .weight_ready  (weight_ready),
    .weight_req    (weight_req),
    .weight        (weight),
    .conv_data_in  (conv_data_in),
    .fc_data_in    (fc_data_in),
    .conv_data_out (conv_data_out),
    .fc_data_out   (fc_data_out),
    .out_conv_valid(out_conv_valid),
    .out_fc_valid  (out_fc_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fill_fc(input logic [5:0] v);
    for (int i = 0; i < 96; i++) fc_data_in[i*6 +: 6] = v;
  endtask

  logic [59:0] fc_exp5;

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    rstn         = 1'b1;
    conv_valid   = 1'b0;
    fc_valid     = 1'b0;
    weight_ready = 1'b0;
    weight       = '0;
    conv_data_in = '0;
    fc_data_in   = '0;
    tick;
    tick;

    // Reset state
    chk("rst_weight_req", 64'(weight_req), 64'd1);
    chk("rst_conv_ready", 64'(conv_ready), 64'd0);
    chk("rst_fc_ready",   64'(fc_ready),   64'd0);
    chk("rst_vld",        64'({out_conv_valid, out_fc_valid}), 64'd0);
    chk("rst_conv_out",   64'(conv_data_out), 64'd0);
    chk("rst_fc_out",     64'(fc_data_out),   64'd0);
    rstn = 1'b0;
    tick;

    // Weight load handshake
    weight       = {96{1'b1}};
    weight_ready = 1'b1;
    tick;
    weight_ready = 1'b0;
    chk("ld_conv_ready", 64'(conv_ready), 64'd1);
    chk("ld_fc_ready",   64'(fc_ready),   64'd1);
    chk("ld_weight_req", 64'(weight_req), 64'd0);

    // Conv: all +x weights on all -1 data -> -16
    conv_data_in = 16'hFFFF;
    conv_valid   = 1'b1;
    tick;
    conv_valid = 1'b0;
    chk("conv_neg_vld", 64'(out_conv_valid), 64'd1);
    chk("conv_neg_out", 64'(conv_data_out), 64'({6{6'h30}}));
    tick;
    chk("conv_pulse_end", 64'(out_conv_valid), 64'd0);
    chk("conv_hold",      64'(conv_data_out), 64'({6{6'h30}}));

    // Conv: all -x weights -> +16
    weight       = '0;
    weight_ready = 1'b1;
    tick;
    weight_ready = 1'b0;
    conv_valid   = 1'b1;
    tick;
    conv_valid = 1'b0;
    chk("conv_pos_out", 64'(conv_data_out), 64'({6{6'h10}}));

    // Conv: mixed per-channel weights on half-window data
    weight       = {16'hFF00, 16'h0001, 16'h00F0, 16'h000F, 16'h0000, 16'hFFFF};
    weight_ready = 1'b1;
    tick;
    weight_ready = 1'b0;
    conv_data_in = 16'h00FF;
    conv_valid   = 1'b1;
    tick;
    conv_valid = 1'b0;
    chk("conv_mix_out", 64'(conv_data_out),
        64'({6'h08, 6'h06, 6'h00, 6'h00, 6'h08, 6'h38}));

    // FC: all +x weights, every term 31 -> 496; weight set consumed
    weight       = {96{1'b1}};
    weight_ready = 1'b1;
    tick;
    weight_ready = 1'b0;
    fill_fc(6'h1F);
    fc_valid = 1'b1;
    tick;
    chk("fc_pos_vld",      64'(out_fc_valid), 64'd1);
    chk("fc_pos_out",      64'(fc_data_out),  64'({6{10'h1F0}}));
    chk("fc_ready_drop",   64'(fc_ready),     64'd0);
    chk("fc_weight_req",   64'(weight_req),   64'd1);

    // FC blocked while no fresh weights
    fill_fc(6'h20);
    tick;
    chk("fc_blk_vld",  64'(out_fc_valid), 64'd0);
    chk("fc_blk_hold", 64'(fc_data_out),  64'({6{10'h1F0}}));
    weight       = '0;
    weight_ready = 1'b1;
    tick;
    weight_ready = 1'b0;
    chk("fc_ld_edge_vld", 64'(out_fc_valid), 64'd0);
    chk("fc_ld_ready",    64'(fc_ready),     64'd1);

    // FC: all -x weights, every term -32 -> +512 overflows
    tick;
    fc_valid = 1'b0;
`ifdef CONV_TOP_SAT_EN
    fc_exp5 = {6{10'h1FF}};
`else
    fc_exp5 = {6{10'h200}};
`endif
    chk("fc_ovf_vld", 64'(out_fc_valid), 64'd1);
    chk("fc_ovf_out", 64'(fc_data_out),  64'(fc_exp5));

    // Load on same edge as conv accept: accept uses old weights, fresh ends at 1
    weight       = {96{1'b1}};
    weight_ready = 1'b1;
    tick;
    weight       = '0;
    conv_data_in = 16'hFFFF;
    conv_valid   = 1'b1;
    fc_valid     = 1'b1;
    fill_fc(6'h01);
    tick;
    weight_ready = 1'b0;
    conv_valid   = 1'b0;
    fc_valid     = 1'b0;
    chk("same_edge_conv", 64'(conv_data_out), 64'({6{6'h30}}));
    chk("same_edge_fc",   64'(fc_data_out),   64'({6{10'h010}}));
    chk("same_edge_fresh", 64'(fc_ready),     64'd1);

    // Reset between accept and result
    conv_valid = 1'b1;
    fc_valid   = 1'b1;
    #2;
    rstn = 1'b1;
    tick;
    conv_valid = 1'b0;
    fc_valid   = 1'b0;
    chk("midrst_vld",   64'({out_conv_valid, out_fc_valid}), 64'd0);
    chk("midrst_conv",  64'(conv_data_out), 64'd0);
    chk("midrst_fc",    64'(fc_data_out),   64'd0);
    chk("midrst_hs",    64'({weight_req, conv_ready, fc_ready}), 64'b100);
    rstn = 1'b0;
    tick;
    chk("midrst_after", 64'({out_conv_valid, out_fc_valid}), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
